// File: rtl/input_debouncer.sv
// Synchronizes a raw asynchronous input and commits a new level only after
// DEBOUNCE_CYCLES consecutive agreeing samples; aborted transitions are counted.
module input_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8,
  parameter bit          RESET_VAL       = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       signal_in,
  input  logic       glitch_clr,
  output logic       signal_out,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  localparam int unsigned GLITCH_W = 8;
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
  localparam bit                  SINGLE     = (DEBOUNCE_CYCLES == 1);

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  s;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  out_next;
  logic                  glitch_evt;
  logic [GLITCH_W-1:0]   glitch_next;

  // Metastability chain; shifts every edge regardless of enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= STABLE;
      cnt        <= '0;
      signal_out <= RESET_VAL;
      busy       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      signal_out <= out_next;
      busy       <= (state_next == CHECK);
      glitch_cnt <= glitch_next;
    end
  end

  // Next-state logic; dropping enable abandons any check in progress.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = STABLE;
    end else begin
      case (state)
        STABLE: begin
          if ((s != signal_out) && !SINGLE) begin
            state_next = CHECK;
          end
        end
        CHECK: begin
          if ((s == signal_out) || (cnt == CNT_LAST)) begin
            state_next = STABLE;
          end
        end
        default: state_next = STABLE;
      endcase
    end
  end

  // Counter, commit and glitch detection.
  always_comb begin
    cnt_next   = '0;
    out_next   = signal_out;
    glitch_evt = 1'b0;
    if (enable) begin
      case (state)
        STABLE: begin
          if (s != signal_out) begin
            if (SINGLE) begin
              out_next = s;
            end else begin
              cnt_next = CNT_ONE;
            end
          end
        end
        CHECK: begin
          if (s == signal_out) begin
            glitch_evt = 1'b1;
          end else if (cnt == CNT_LAST) begin
            out_next = s;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: cnt_next = '0;
      endcase
    end
  end

  // Saturating glitch counter; clear has priority over a same-cycle glitch.
  always_comb begin
    glitch_next = glitch_cnt;
    if (glitch_clr) begin
      glitch_next = '0;
    end else if (glitch_evt && (glitch_cnt != GLITCH_MAX)) begin
      glitch_next = glitch_cnt + GLITCH_W'(1);
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed scenarios plus random
// stimulus, compared against a run-length reference model.
module tb_input_debouncer;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DC   = 4;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       signal_in;
  logic       glitch_clr;
  logic       signal_out;
  logic       busy;
  logic [7:0] glitch_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic m_out;
  int   m_run;
  int   m_g;
  logic mq[$];

  input_debouncer #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(8),
    .RESET_VAL(1'b0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .signal_in(signal_in),
    .glitch_clr(glitch_clr),
    .signal_out(signal_out),
    .busy(busy),
    .glitch_cnt(glitch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: s is the input seen SYNC edges earlier; a level commits after DC
  // consecutive enabled mismatching samples, a shorter run is a glitch.
  always @(posedge clk or negedge reset_n) begin
    logic sm;
    logic glitch;
    if (!reset_n) begin
      mq.delete();
      for (int i = 0; i < int'(SYNC); i++) mq.push_back(1'b0);
      m_out = 1'b0;
      m_run = 0;
      m_g   = 0;
    end else begin
      sm = mq.pop_front();
      mq.push_back(signal_in);
      glitch = 1'b0;
      if (enable) begin
        if (sm != m_out) begin
          m_run++;
          if (m_run == int'(DC)) begin
            m_out = sm;
            m_run = 0;
          end
        end else begin
          if (m_run > 0) glitch = 1'b1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (glitch_clr) m_g = 0;
      else if (glitch && m_g < 255) m_g++;
    end
  end

  task automatic step(input logic v);
    signal_in = v;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (signal_out !== 1'b0 || busy !== 1'b0 || glitch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: got out=%0b busy=%0b g=%0d want 0/0/0", signal_out, busy, glitch_cnt);
    end
    reset_n = 1'b1;
    repeat (4) step(1'b0);
    checks++;
    if (signal_out !== 1'b0 || busy !== 1'b0 || glitch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_idle: got out=%0b busy=%0b g=%0d want 0/0/0", signal_out, busy, glitch_cnt);
    end
  endtask

  task automatic test_clean_step;
    for (int i = 0; i <= 5; i++) begin
      step(1'b1);
      checks++;
      if (busy !== ((i >= 2 && i < 5) ? 1'b1 : 1'b0) || busy !== (m_run > 0)) begin
        errors++;
        $display("FAIL clean_busy[E0+%0d]: got %0b model %0b", i, busy, (m_run > 0));
      end
      checks++;
      if (signal_out !== ((i >= 5) ? 1'b1 : 1'b0) || signal_out !== m_out) begin
        errors++;
        $display("FAIL clean_out[E0+%0d]: got %0b model %0b", i, signal_out, m_out);
      end
    end
    repeat (8) step(1'b0);
    checks++;
    if (signal_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clean_fall: got out=%0b busy=%0b want 0/0", signal_out, busy);
    end
  endtask

  task automatic test_glitch;
    int g0;
    g0 = m_g;
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      checks++;
      if (signal_out !== 1'b0) begin
        errors++;
        $display("FAIL glitch_out[%0d]: got %0b want 0", i, signal_out);
      end
    end
    checks++;
    if (busy !== 1'b0 || glitch_cnt !== 8'(g0 + 1) || glitch_cnt !== 8'(m_g)) begin
      errors++;
      $display("FAIL glitch_count: got busy=%0b g=%0d want busy=0 g=%0d", busy, glitch_cnt, g0 + 1);
    end
  endtask

  task automatic test_bounce_train;
    int g0;
    int rises;
    logic prev;
    int hi;
    int lo;
    g0 = m_g;
    rises = 0;
    prev = signal_out;
    for (int p = 0; p < 10; p++) begin
      hi = $urandom_range(1, 3);
      lo = $urandom_range(1, 3);
      for (int k = 0; k < hi + lo; k++) begin
        step((k < hi) ? 1'b1 : 1'b0);
        if (signal_out === 1'b1 && prev === 1'b0) rises++;
        prev = signal_out;
      end
    end
    for (int j = 0; j < 10; j++) begin
      step(1'b1);
      if (signal_out === 1'b1 && prev === 1'b0) rises++;
      prev = signal_out;
      if (j == 4 || j == 5) begin
        checks++;
        if (signal_out !== ((j == 5) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL bounce_commit[E0+%0d]: got %0b want %0b", j, signal_out, (j == 5));
        end
      end
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL bounce_rises: got %0d want 1", rises);
    end
    checks++;
    if (glitch_cnt !== 8'(g0 + 10) || glitch_cnt !== 8'(m_g)) begin
      errors++;
      $display("FAIL bounce_glitches: got %0d want %0d", glitch_cnt, g0 + 10);
    end
    repeat (8) step(1'b0);
  endtask

  task automatic test_saturation_clear;
    for (int i = 0; i < 300; i++) begin
      step(1'b1);
      step(1'b0);
    end
    repeat (3) step(1'b0);
    checks++;
    if (glitch_cnt !== 8'd255 || glitch_cnt !== 8'(m_g)) begin
      errors++;
      $display("FAIL sat_count: got %0d want 255", glitch_cnt);
    end
    step(1'b1);
    step(1'b0);
    step(1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL sat_in_check: got busy=%0b want 1", busy);
    end
    glitch_clr = 1'b1;
    step(1'b0);
    glitch_clr = 1'b0;
    checks++;
    if (glitch_cnt !== 8'd0 || busy !== 1'b0 || glitch_cnt !== 8'(m_g)) begin
      errors++;
      $display("FAIL clr_wins: got g=%0d busy=%0b want 0/0", glitch_cnt, busy);
    end
  endtask

  task automatic test_enable_drop;
    int g0;
    g0 = m_g;
    repeat (4) step(1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL en_pre_busy: got %0b want 1", busy);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      checks++;
      if (busy !== 1'b0 || signal_out !== 1'b0) begin
        errors++;
        $display("FAIL en_hold[%0d]: got busy=%0b out=%0b want 0/0", i, busy, signal_out);
      end
    end
    enable = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step(1'b1);
      checks++;
      if (signal_out !== ((j == 3) ? 1'b1 : 1'b0) || signal_out !== m_out) begin
        errors++;
        $display("FAIL en_commit[%0d]: got %0b want %0b", j, signal_out, (j == 3));
      end
    end
    checks++;
    if (glitch_cnt !== 8'(g0)) begin
      errors++;
      $display("FAIL en_glitch: got %0d want %0d", glitch_cnt, g0);
    end
    repeat (8) step(1'b0);
  endtask

  task automatic test_reset_mid_check;
    step(1'b1);
    repeat (3) step(1'b0);
    checks++;
    if (glitch_cnt !== 8'd1) begin
      errors++;
      $display("FAIL rst_pre_glitch: got %0d want 1", glitch_cnt);
    end
    repeat (3) step(1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_busy: got %0b want 1", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (signal_out !== 1'b0 || busy !== 1'b0 || glitch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_async: got out=%0b busy=%0b g=%0d want 0/0/0", signal_out, busy, glitch_cnt);
    end
    #1 reset_n = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if (signal_out !== ((i >= 5) ? 1'b1 : 1'b0) || signal_out !== m_out) begin
        errors++;
        $display("FAIL rst_recommit[E0+%0d]: got %0b want %0b", i, signal_out, (i >= 5));
      end
    end
  endtask

  task automatic test_random;
    int   len;
    logic cur;
    int   since;
    logic prev;
    len = 0;
    cur = 1'b0;
    since = 1000;
    prev = signal_out;
    for (int i = 0; i < 800; i++) begin
      if (len == 0) begin
        cur = 1'($urandom_range(0, 1));
        len = $urandom_range(1, 8);
      end
      len--;
      enable = ($urandom_range(0, 15) != 0);
      glitch_clr = ($urandom_range(0, 31) == 0);
      step(cur);
      checks++;
      if (signal_out !== m_out || busy !== (m_run > 0) || glitch_cnt !== 8'(m_g)) begin
        errors++;
        $display("FAIL rand[%0d]: got out=%0b busy=%0b g=%0d model %0b/%0b/%0d",
                 i, signal_out, busy, glitch_cnt, m_out, (m_run > 0), m_g);
      end
      if (signal_out !== prev) begin
        checks++;
        if (since < int'(DC) - 1) begin
          errors++;
          $display("FAIL rand_spacing[%0d]: got gap %0d want >= %0d", i, since + 1, DC);
        end
        since = 0;
      end else begin
        since++;
      end
      prev = signal_out;
    end
    enable = 1'b1;
    glitch_clr = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b1;
    signal_in  = 1'b0;
    glitch_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce_train();
    test_saturation_clear();
    test_enable_drop();
    test_reset_mid_check();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
